// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer: condition codes, FSM states,
// default control-store depth and the opcode dispatch table.
package micro_sequencer_pkg;

    localparam int unsigned UCODE_DEPTH_DEFAULT = 75;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_NZ     = 2'b10;
    localparam logic [1:0] COND_HALT   = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_STALL = 2'd2;
    localparam state_t ST_HALT  = 2'd3;

    // Opcode -> microroutine start address; opcodes not listed are unmapped.
    localparam int DISPATCH_N = 8;

    localparam logic [7:0] DISPATCH_OPC [DISPATCH_N] = '{
        8'h00, 8'h03, 8'h11, 8'h22, 8'h35, 8'h4A, 8'h80, 8'hF0
    };

    localparam logic [15:0] DISPATCH_ADDR [DISPATCH_N] = '{
        16'd10, 16'd27, 16'd20, 16'd33, 16'd45, 16'd52, 16'd60, 16'd74
    };

    function automatic logic [15:0] zext_jump(input logic [6:0] jump);
        return {9'b0, jump};
    endfunction

endpackage

// File: rtl/micro_dispatch.sv
// Combinational opcode dispatch: maps an instruction opcode to the start
// address of its microroutine and flags opcodes that have no routine.
module micro_dispatch
    import micro_sequencer_pkg::*;
#(
    parameter int unsigned OPC_W = 8
) (
    input  logic [OPC_W-1:0] ir_opcode,
    output logic [15:0]      start_addr,
    output logic             valid
);

    // Compare at a common width so a narrow opcode never aliases a wide table entry.
    localparam int unsigned CMP_W = (OPC_W > 8) ? OPC_W : 8;

    always_comb begin
        start_addr = '0;
        valid      = 1'b0;
        for (int i = 0; i < DISPATCH_N; i++) begin
            if (CMP_W'(ir_opcode) == CMP_W'(DISPATCH_OPC[i])) begin
                start_addr = DISPATCH_ADDR[i];
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: steps the control-store address, handles branches,
// dispatch, memory stalls and halts. Optional single-step via MICRO_SEQUENCER_STEP_EN.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int unsigned UCODE_DEPTH = UCODE_DEPTH_DEFAULT,
    parameter int unsigned OPC_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MICRO_SEQUENCER_STEP_EN
    input  logic             step,
`endif
    input  logic             start,
    input  logic             bt,
    input  logic [1:0]       condition,
    input  logic [6:0]       jump_addr,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             z_flag,
    input  logic             mem_wait,
    output logic [15:0]      mpc,
    output logic             ops_valid,
    output logic             running,
    output logic             halted,
    output logic             err,
    output logic [15:0]      retired
);

    state_t      state_q, state_d;
    logic [15:0] mpc_q, mpc_d;
    logic [15:0] retired_q, retired_d;
    logic        err_q, err_d;

    logic        step_ok;
    logic        exec;
    logic [15:0] disp_addr;
    logic        disp_valid;
    logic [15:0] next_addr;
    logic        halt_req;
    logic        bad_addr;

`ifdef MICRO_SEQUENCER_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    micro_dispatch #(
        .OPC_W(OPC_W)
    ) u_dispatch (
        .ir_opcode (ir_opcode),
        .start_addr(disp_addr),
        .valid     (disp_valid)
    );

    assign exec = (state_q == ST_RUN) && !mem_wait && step_ok;

    // Target of the current control word; bt overrides the condition field.
    always_comb begin
        next_addr = mpc_q;
        halt_req  = 1'b0;
        bad_addr  = 1'b0;
        if (bt) begin
            next_addr = disp_addr;
            bad_addr  = !disp_valid;
        end else begin
            case (condition)
                COND_ALWAYS: next_addr = zext_jump(jump_addr);
                COND_Z:      next_addr = z_flag ? zext_jump(jump_addr) : mpc_q + 16'd1;
                COND_NZ:     next_addr = z_flag ? mpc_q + 16'd1 : zext_jump(jump_addr);
                default:     halt_req  = 1'b1;
            endcase
        end
        if (!halt_req && (32'(next_addr) >= UCODE_DEPTH)) begin
            bad_addr = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        mpc_d     = mpc_q;
        retired_d = retired_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d   = ST_RUN;
                    mpc_d     = '0;
                    retired_d = '0;
                    err_d     = 1'b0;
                end
            end
            ST_RUN: begin
                if (mem_wait) begin
                    state_d = ST_STALL;
                end else if (exec) begin
                    if (retired_q != 16'hFFFF) begin
                        retired_d = retired_q + 16'd1;
                    end
                    if (bad_addr) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else if (halt_req) begin
                        state_d = ST_HALT;
                    end else begin
                        mpc_d = next_addr;
                    end
                end
            end
            ST_STALL: begin
                if (!mem_wait) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mpc_q     <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mpc_q     <= mpc_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    assign mpc       = mpc_q;
    assign ops_valid = exec;
    assign running   = (state_q == ST_RUN) || (state_q == ST_STALL);
    assign halted    = (state_q == ST_HALT);
    assign err       = err_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed vector table, async reset
// sequence, then randomized traffic against a behavioural model.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        bt = 1'b0;
    logic [1:0]  condition = 2'b00;
    logic [6:0]  jump_addr = '0;
    logic [7:0]  ir_opcode = '0;
    logic        z_flag = 1'b0;
    logic        mem_wait = 1'b0;
    logic [15:0] mpc;
    logic        ops_valid, running, halted, err;
    logic [15:0] retired;
`ifdef MICRO_SEQUENCER_STEP_EN
    logic        step = 1'b1;
`endif

    micro_sequencer dut (
        .clk      (clk),
        .rst      (rst),
`ifdef MICRO_SEQUENCER_STEP_EN
        .step     (step),
`endif
        .start    (start),
        .bt       (bt),
        .condition(condition),
        .jump_addr(jump_addr),
        .ir_opcode(ir_opcode),
        .z_flag   (z_flag),
        .mem_wait (mem_wait),
        .mpc      (mpc),
        .ops_valid(ops_valid),
        .running  (running),
        .halted   (halted),
        .err      (err),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_mpc, input logic e_valid,
                           input logic e_run, input logic e_halt, input logic e_err,
                           input logic [15:0] e_ret);
        chk({tag, ".mpc"}, mpc, e_mpc);
        chk({tag, ".ops_valid"}, 16'(ops_valid), 16'(e_valid));
        chk({tag, ".running"}, 16'(running), 16'(e_run));
        chk({tag, ".halted"}, 16'(halted), 16'(e_halt));
        chk({tag, ".err"}, 16'(err), 16'(e_err));
        chk({tag, ".retired"}, retired, e_ret);
    endtask

    typedef struct {
        logic        s;
        logic        b;
        logic [1:0]  c;
        logic [6:0]  j;
        logic [7:0]  o;
        logic        z;
        logic        mw;
        logic [15:0] e_mpc;
        logic        e_valid;
        logic        e_run;
        logic        e_halt;
        logic        e_err;
        logic [15:0] e_ret;
    } vec_t;

    function automatic vec_t v(input logic s, input logic b, input logic [1:0] c,
                               input logic [6:0] j, input logic [7:0] o, input logic z,
                               input logic mw, input logic [15:0] em, input logic ev,
                               input logic er, input logic eh, input logic ee,
                               input logic [15:0] eret);
        vec_t r;
        r.s = s; r.b = b; r.c = c; r.j = j; r.o = o; r.z = z; r.mw = mw;
        r.e_mpc = em; r.e_valid = ev; r.e_run = er; r.e_halt = eh; r.e_err = ee;
        r.e_ret = eret;
        return r;
    endfunction

    task automatic drive(input logic s, input logic b, input logic [1:0] c, input logic [6:0] j,
                         input logic [7:0] o, input logic z, input logic mw);
        start = s; bt = b; condition = c; jump_addr = j; ir_opcode = o; z_flag = z;
        mem_wait = mw;
    endtask

    // Behavioural model: mode 0 idle, 1 run, 2 stall, 3 halt.
    int          m_mode, m_mpc, m_ret;
    logic        m_err;
    int          disp_map[int];
    localparam int DEPTH = 75;

    task automatic model_step();
        int t;
        case (m_mode)
            0: if (start) m_mode = 1;
            1: begin
                if (mem_wait) m_mode = 2;
                else begin
                    if (m_ret < 65535) m_ret++;
                    t = -2;
                    if (bt) t = disp_map.exists(int'(ir_opcode)) ? disp_map[int'(ir_opcode)] : -1;
                    else if (condition == 2'd0) t = int'(jump_addr);
                    else if (condition == 2'd1) t = z_flag ? int'(jump_addr) : m_mpc + 1;
                    else if (condition == 2'd2) t = !z_flag ? int'(jump_addr) : m_mpc + 1;
                    if (t == -2) m_mode = 3;
                    else if (t < 0 || t >= DEPTH) begin m_err = 1'b1; m_mode = 3; end
                    else m_mpc = t;
                end
            end
            2: if (!mem_wait) m_mode = 1;
            default: if (start) begin m_mode = 1; m_mpc = 0; m_err = 1'b0; m_ret = 0; end
        endcase
    endtask

    vec_t vecs[$];
    logic [7:0] mapped[8] = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h35, 8'h4A, 8'h80, 8'hF0};
    int         addrs[8]  = '{10, 27, 20, 33, 45, 52, 60, 74};

    initial begin
        for (int i = 0; i < 8; i++) disp_map[int'(mapped[i])] = addrs[i];

        //            s  b  c      j    o      z  mw   mpc v  r  h  e  ret
        vecs.push_back(v(1, 0, 2'd0, 0,   8'h00, 0, 0,  0,  0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 2'd0, 1,   8'h00, 0, 0,  0,  1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 2'd0, 2,   8'h00, 0, 0,  1,  1, 1, 0, 0, 1));
        vecs.push_back(v(0, 0, 2'd0, 12,  8'h00, 0, 0,  2,  1, 1, 0, 0, 2));
        vecs.push_back(v(0, 0, 2'd0, 66,  8'h00, 0, 1,  12, 0, 1, 0, 0, 3));
        vecs.push_back(v(0, 0, 2'd0, 66,  8'h00, 0, 1,  12, 0, 1, 0, 0, 3));
        vecs.push_back(v(0, 0, 2'd0, 66,  8'h00, 0, 1,  12, 0, 1, 0, 0, 3));
        vecs.push_back(v(0, 0, 2'd0, 66,  8'h00, 0, 0,  12, 0, 1, 0, 0, 3));
        vecs.push_back(v(0, 0, 2'd0, 66,  8'h00, 0, 0,  12, 1, 1, 0, 0, 3));
        vecs.push_back(v(0, 0, 2'd1, 69,  8'h00, 1, 0,  66, 1, 1, 0, 0, 4));
        vecs.push_back(v(0, 0, 2'd0, 66,  8'h00, 0, 0,  69, 1, 1, 0, 0, 5));
        vecs.push_back(v(0, 0, 2'd1, 69,  8'h00, 0, 0,  66, 1, 1, 0, 0, 6));
        vecs.push_back(v(0, 0, 2'd2, 40,  8'h00, 1, 0,  67, 1, 1, 0, 0, 7));
        vecs.push_back(v(0, 0, 2'd2, 40,  8'h00, 0, 0,  68, 1, 1, 0, 0, 8));
        vecs.push_back(v(0, 0, 2'd3, 0,   8'h00, 0, 1,  40, 0, 1, 0, 0, 9));
        vecs.push_back(v(0, 0, 2'd3, 0,   8'h00, 0, 0,  40, 0, 1, 0, 0, 9));
        vecs.push_back(v(0, 0, 2'd3, 0,   8'h00, 0, 0,  40, 1, 1, 0, 0, 9));
        vecs.push_back(v(0, 0, 2'd0, 0,   8'h00, 0, 0,  40, 0, 0, 1, 0, 10));
        vecs.push_back(v(1, 0, 2'd0, 0,   8'h00, 0, 0,  40, 0, 0, 1, 0, 10));
        vecs.push_back(v(0, 1, 2'd3, 0,   8'h03, 0, 0,  0,  1, 1, 0, 0, 0));
        vecs.push_back(v(0, 1, 2'd0, 0,   8'h55, 0, 0,  27, 1, 1, 0, 0, 1));
        vecs.push_back(v(0, 0, 2'd0, 0,   8'h00, 0, 0,  27, 0, 0, 1, 1, 2));
        vecs.push_back(v(1, 0, 2'd0, 0,   8'h00, 0, 0,  27, 0, 0, 1, 1, 2));
        vecs.push_back(v(0, 0, 2'd0, 80,  8'h00, 0, 0,  0,  1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 2'd0, 0,   8'h00, 0, 0,  0,  0, 0, 1, 1, 1));
        vecs.push_back(v(1, 0, 2'd0, 0,   8'h00, 0, 0,  0,  0, 0, 1, 1, 1));
        vecs.push_back(v(0, 0, 2'd0, 74,  8'h00, 0, 0,  0,  1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 2'd1, 10,  8'h00, 0, 0,  74, 1, 1, 0, 0, 1));
        vecs.push_back(v(0, 0, 2'd0, 0,   8'h00, 0, 0,  74, 0, 0, 1, 1, 2));
        vecs.push_back(v(1, 0, 2'd0, 0,   8'h00, 0, 0,  74, 0, 0, 1, 1, 2));
        vecs.push_back(v(1, 0, 2'd0, 5,   8'h00, 0, 0,  0,  1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 2'd0, 33,  8'h00, 0, 0,  5,  1, 1, 0, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].b, vecs[i].c, vecs[i].j, vecs[i].o, vecs[i].z, vecs[i].mw);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].e_mpc, vecs[i].e_valid, vecs[i].e_run,
                    vecs[i].e_halt, vecs[i].e_err, vecs[i].e_ret);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a RUN cycle at mpc=33.
        drive(0, 0, 2'd0, 34, 8'h00, 0, 0);
        chk("pre_rst.mpc", mpc, 16'd33);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all("idle_after_rst", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Randomized traffic against the model.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_mode = 0; m_mpc = 0; m_ret = 0; m_err = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            start     = (m_mode == 0 || m_mode == 3) ? ($urandom_range(0, 3) == 0)
                                                     : ($urandom_range(0, 15) == 0);
            bt        = ($urandom_range(0, 5) == 0);
            ir_opcode = ($urandom_range(0, 9) < 7) ? mapped[$urandom_range(0, 7)]
                                                  : 8'($urandom);
            condition = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            jump_addr = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 74));
            z_flag    = 1'($urandom);
            mem_wait  = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            chk_all($sformatf("rnd%0d", n), 16'(m_mpc), (m_mode == 1) && !mem_wait,
                    (m_mode == 1) || (m_mode == 2), m_mode == 3, m_err, 16'(m_ret));
            model_step();
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
